// File: rtl/latch_sr_sequencer_if.sv
// Signal bundle between a requester/latch environment and latch_sr_sequencer.
// The master side issues requests and returns latch readback; the slave side drives the latch.
interface latch_sr_sequencer_if;
    logic request_set;
    logic request_reset;
    logic signal_q;
    logic signal_q_;
    logic latch_enable;
    logic latch_set;
    logic latch_reset;
    logic busy;
    logic done;
    logic conflict;
    logic mismatch;

    modport master (
        output request_set, request_reset, signal_q, signal_q_,
        input  latch_enable, latch_set, latch_reset, busy, done, conflict, mismatch
    );

    modport slave (
        input  request_set, request_reset, signal_q, signal_q_,
        output latch_enable, latch_set, latch_reset, busy, done, conflict, mismatch
    );
endinterface

// File: rtl/latch_sr_sequencer.sv
// Sequences single-cycle set/reset requests into a safe gated-SR-latch write:
// S/R setup with enable low, enable pulse, S/R hold, then a readback check.
module latch_sr_sequencer #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned CNT_WIDTH    = 4
) (
    input logic                 clock,
    input logic                 reset,
    latch_sr_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StCheck
    } state_e;

    localparam logic [CNT_WIDTH-1:0] SetupLast = CNT_WIDTH'(SETUP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PulseLast = CNT_WIDTH'(PULSE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HoldLast  = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 expected_q, expected_d;
    logic                 enable_q, enable_d;
    logic                 set_q, set_d;
    logic                 rst_q, rst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 conflict_q, conflict_d;
    logic                 mismatch_q, mismatch_d;

    // Outputs are registered from the next state so each lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CntOne;
        expected_d = expected_q;
        enable_d   = 1'b0;
        set_d      = set_q;
        rst_d      = rst_q;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        conflict_d = 1'b0;
        mismatch_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                set_d  = 1'b0;
                rst_d  = 1'b0;
                if (bus.request_set && !bus.request_reset) begin
                    state_d    = StSetup;
                    expected_d = 1'b1;
                    set_d      = 1'b1;
                    busy_d     = 1'b1;
                end else if (bus.request_reset && !bus.request_set) begin
                    state_d    = StSetup;
                    expected_d = 1'b0;
                    rst_d      = 1'b1;
                    busy_d     = 1'b1;
                end else if (bus.request_set && bus.request_reset) begin
                    conflict_d = 1'b1;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d  = StPulse;
                    cnt_d    = '0;
                    enable_d = 1'b1;
                end
            end
            StPulse: begin
                enable_d = 1'b1;
                if (cnt_q == PulseLast) begin
                    state_d  = StHold;
                    cnt_d    = '0;
                    enable_d = 1'b0;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end
            end
            StCheck: begin
                state_d = StIdle;
                cnt_d   = '0;
                busy_d  = 1'b0;
                set_d   = 1'b0;
                rst_d   = 1'b0;
                done_d  = 1'b1;
                // Unknown readback falls into the else branch and reports a mismatch.
                if ((bus.signal_q == expected_q) && (bus.signal_q_ == !expected_q)) begin
                    mismatch_d = 1'b0;
                end else begin
                    mismatch_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                busy_d  = 1'b0;
                set_d   = 1'b0;
                rst_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            expected_q <= 1'b0;
            enable_q   <= 1'b0;
            set_q      <= 1'b0;
            rst_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            expected_q <= expected_d;
            enable_q   <= enable_d;
            set_q      <= set_d;
            rst_q      <= rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.latch_enable = enable_q;
    assign bus.latch_set    = set_q;
    assign bus.latch_reset  = rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.conflict     = conflict_q;
    assign bus.mismatch     = mismatch_q;

endmodule

// File: tb/tb_latch_sr_sequencer.sv
// Bench for latch_sr_sequencer: directed and random requests against a timeline model
// of the write sequence, with a gated SR latch closing the readback loop.
module tb_latch_sr_sequencer;
    localparam int S    = 2;
    localparam int P    = 4;
    localparam int H    = 2;
    localparam int BUSY = S + P + H + 1;
    localparam int IDLE_AGE = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;

    latch_sr_sequencer_if bus ();

    latch_sr_sequencer #(
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .HOLD_CYCLES (H),
        .CNT_WIDTH   (4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: age = cycles since the accepting edge (IDLE_AGE when no sequence is running).
    int age     = IDLE_AGE;
    bit m_exp   = 1'b0;
    bit m_conf  = 1'b0;
    bit m_mm    = 1'b0;
    bit latch_q = 1'b0;
    bit force_rb = 1'b0;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic step(input bit rs, input bit rr, input bit rst);
        logic rb_q, rb_qn;
        bit   idle, e_busy, e_en, e_done;
        bus.request_set   = rs;
        bus.request_reset = rr;
        reset             = rst;
        rb_q  = bus.signal_q;
        rb_qn = bus.signal_q_;
        @(posedge clock);
        idle   = (age > BUSY);
        m_conf = 1'b0;
        m_mm   = 1'b0;
        if (rst) begin
            age   = IDLE_AGE;
            m_exp = 1'b0;
        end else if (idle) begin
            if (rs != rr) begin
                age   = 1;
                m_exp = rs;
            end else begin
                m_conf = rs & rr;
                age    = IDLE_AGE;
            end
        end else begin
            if (age == BUSY) m_mm = !((rb_q === m_exp) && (rb_qn === !m_exp));
            age++;
        end
        #1;
        e_busy = (age >= 1) && (age <= BUSY);
        e_en   = (age > S) && (age <= S + P);
        e_done = (age == BUSY + 1);
        check("busy", bus.busy, e_busy);
        check("latch_enable", bus.latch_enable, e_en);
        check("latch_set", bus.latch_set, e_busy && m_exp);
        check("latch_reset", bus.latch_reset, e_busy && !m_exp);
        check("done", bus.done, e_done);
        check("mismatch", bus.mismatch, e_done && m_mm);
        check("conflict", bus.conflict, m_conf);
        // Gated SR latch driven by the DUT.
        if (bus.latch_enable === 1'b1) begin
            if (bus.latch_set === 1'b1 && bus.latch_reset !== 1'b1) latch_q = 1'b1;
            else if (bus.latch_reset === 1'b1 && bus.latch_set !== 1'b1) latch_q = 1'b0;
        end
        bus.signal_q  = force_rb ? 1'b0 : latch_q;
        bus.signal_q_ = force_rb ? 1'b1 : !latch_q;
    endtask

    initial begin
        bus.request_set   = 1'b0;
        bus.request_reset = 1'b0;
        bus.signal_q      = 1'b0;
        bus.signal_q_     = 1'b1;

        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Set write, then reset write.
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        check("latch_q_after_set", latch_q, 1'b1);
        step(0, 1, 0);
        repeat (10) step(0, 0, 0);
        check("latch_q_after_reset", latch_q, 1'b0);

        // Conflicting requests.
        step(1, 1, 0);
        repeat (3) step(0, 0, 0);

        // Reset request during PULSE of a set sequence is ignored.
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        repeat (9) step(0, 0, 0);
        check("latch_q_ignored_req", latch_q, 1'b1);

        // Forced readback during a set sequence.
        force_rb = 1'b1;
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        force_rb = 1'b0;
        step(0, 0, 0);

        // Block reset on the 2nd PULSE cycle, then a fresh set.
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        check("latch_q_after_abort", latch_q, 1'b1);

        // Request held through done restarts immediately.
        repeat (12) step(0, 1, 0);
        repeat (10) step(0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            force_rb = ($urandom_range(7) == 0);
            step($urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(60) == 0);
        end
        force_rb = 1'b0;
        repeat (12) step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
